// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction buffer between predecode and decode.
// Takes up to IN_WIDTH lane-tagged instructions per cycle. Set lanes are
// compacted in lane order, and up to OUT_WIDTH entries are released per
// cycle in program order.
// Optional macro IBUF_BYPASS_EN: when the buffer is empty, an accepted
// packet drives the outputs in the same cycle. If decode takes those
// instructions, they are never written into storage.
module inst_buffer #(
  parameter  int DEPTH     = 16,
  parameter  int IN_WIDTH  = 8,
  parameter  int OUT_WIDTH = 4,
  parameter  int FSQ_W     = 4,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = PW + 1,
  localparam int OW        = $clog2(IN_WIDTH)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [IN_WIDTH-1:0]                  in_en,
  input  logic [IN_WIDTH-1:0][31:0]            in_inst,
  input  logic [FSQ_W-1:0]                     in_fsqIdx,
  output logic                                 full,
  input  logic                                 flush,
  input  logic                                 out_ready,
  output logic [OUT_WIDTH-1:0]                 out_en,
  output logic [OUT_WIDTH-1:0][31:0]           out_inst,
  output logic [OUT_WIDTH-1:0][FSQ_W-1:0]      out_fsqIdx,
  output logic [OUT_WIDTH-1:0][OW-1:0]         out_offset,
  output logic [CW-1:0]                        count
);

  typedef struct packed {
    logic [31:0]      inst;
    logic [FSQ_W-1:0] fsq;
    logic [OW-1:0]    off;
  } ent_t;

  ent_t          mem_q [DEPTH];
  ent_t          mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  ent_t          lane_ent  [IN_WIDTH];
  logic [CW-1:0] lane_rank [IN_WIDTH];
  logic [CW-1:0] in_num, avail, deq_num, enq_num, skip;
  logic          accept;

  // Full is judged against the registered count only. Same-cycle dequeues
  // are not counted, so the check is conservative.
  assign full   = (CW'(DEPTH) - count_q) < CW'(IN_WIDTH);
  assign accept = (|in_en) && !full && !flush;
  assign avail  = (count_q < CW'(OUT_WIDTH)) ? count_q : CW'(OUT_WIDTH);
  assign deq_num = (out_ready && !flush) ? avail : '0;
  assign enq_num = accept ? (in_num - skip) : '0;
  assign count  = count_q;

  // Rank each set lane among the set lanes below it; the final value is the packet size
  always_comb begin
    in_num = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      lane_rank[k] = in_num;
      lane_ent[k]  = '{inst: in_inst[k], fsq: in_fsqIdx, off: OW'(k)};
      if (in_en[k]) in_num = in_num + CW'(1);
    end
  end

`ifdef IBUF_BYPASS_EN
  ent_t          byp_ent [OUT_WIDTH];
  logic [CW-1:0] byp_num;
  logic          byp_act;

  // Compacted head of the incoming packet; it is shown directly when the buffer is empty
  always_comb begin
    byp_num = (in_num < CW'(OUT_WIDTH)) ? in_num : CW'(OUT_WIDTH);
    byp_act = accept && (count_q == '0);
    for (int i = 0; i < OUT_WIDTH; i++) begin
      byp_ent[i] = '0;
      for (int k = 0; k < IN_WIDTH; k++)
        if (in_en[k] && lane_rank[k] == CW'(i)) byp_ent[i] = lane_ent[k];
    end
  end

  assign skip = (byp_act && out_ready) ? byp_num : '0;
`else
  assign skip = '0;
`endif

  // Next state: compacted writes from tail, pointer and count updates; flush wins
  always_comb begin
    mem_d = mem_q;
    if (accept)
      for (int k = 0; k < IN_WIDTH; k++)
        if (in_en[k] && lane_rank[k] >= skip)
          mem_d[tail_q + PW'(lane_rank[k] - skip)] = lane_ent[k];
    head_d  = head_q + PW'(deq_num);
    tail_d  = tail_q + PW'(enq_num);
    count_d = count_q + enq_num - deq_num;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Output slots read from head onward; they are valid while slot < min(count, OUT_WIDTH)
  always_comb begin
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_en[i]     = CW'(i) < avail;
      out_inst[i]   = mem_q[head_q + PW'(i)].inst;
      out_fsqIdx[i] = mem_q[head_q + PW'(i)].fsq;
      out_offset[i] = mem_q[head_q + PW'(i)].off;
`ifdef IBUF_BYPASS_EN
      if (byp_act) begin
        out_en[i]     = CW'(i) < byp_num;
        out_inst[i]   = byp_ent[i].inst;
        out_fsqIdx[i] = byp_ent[i].fsq;
        out_offset[i] = byp_ent[i].off;
      end
`endif
    end
  end

  // Pointer and count registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; it is only read behind valid slots
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: directed and randomized stimulus for inst_buffer.
// The outputs are checked every cycle against a queue model of the buffer.
module tb_inst_buffer;

`ifdef IBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, flush, out_ready, full;
  logic [7:0]       in_en;
  logic [7:0][31:0] in_inst;
  logic [3:0]       in_fsqIdx;
  logic [3:0]       out_en;
  logic [3:0][31:0] out_inst;
  logic [3:0][3:0]  out_fsqIdx;
  logic [3:0][2:0]  out_offset;
  logic [4:0]       count;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  inst_buffer dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_inst(in_inst), .in_fsqIdx(in_fsqIdx),
    .full(full), .flush(flush), .out_ready(out_ready), .out_en(out_en),
    .out_inst(out_inst), .out_fsqIdx(out_fsqIdx), .out_offset(out_offset), .count(count)
  );

  typedef struct {
    logic [31:0] inst;
    logic [3:0]  fsq;
    logic [2:0]  off;
  } ent_t;

  ent_t q[$];    // buffer contents, oldest first
  ent_t pkt[$];  // compacted current input packet

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic void build_pkt();
    pkt.delete();
    for (int k = 0; k < 8; k++)
      if (in_en[k]) pkt.push_back('{inst: in_inst[k], fsq: in_fsqIdx, off: 3'(k)});
  endfunction

  function automatic bit model_full();
    return (16 - q.size()) < 8;
  endfunction

  function automatic int min4(input int a);
    return (a < 4) ? a : 4;
  endfunction

  // Advance the model by one clock edge, using the inputs present at that edge
  task automatic model_update();
    int deq, skip;
    bit acc;
    if (rst || flush) begin
      q.delete();
      return;
    end
    build_pkt();
    acc  = (in_en != 0) && !model_full();
    deq  = out_ready ? min4(q.size()) : 0;
    skip = (BYP && acc && q.size() == 0 && out_ready) ? min4(pkt.size()) : 0;
    repeat (deq) void'(q.pop_front());
    if (acc) for (int j = skip; j < pkt.size(); j++) q.push_back(pkt[j]);
  endtask

  // Per-cycle comparison of all outputs against the model
  ent_t src[$];
  int   nexp;
  always @(negedge clk) if (armed) begin
    build_pkt();
    if (BYP && q.size() == 0 && (in_en != 0) && !flush && !model_full()) src = pkt;
    else src = q;
    nexp = min4(src.size());
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(model_full()));
    chk("out_en", 64'(out_en), 64'((1 << nexp) - 1));
    for (int i = 0; i < nexp; i++)
      chk($sformatf("slot%0d", i), {25'b0, out_inst[i], out_fsqIdx[i], out_offset[i]},
          {25'b0, src[i].inst, src[i].fsq, src[i].off});
  end

  task automatic drive(input logic [7:0] en, input logic [7:0][31:0] ins, input logic [3:0] f,
                       input logic rdy, input logic fl, input logic r);
    in_en = en; in_inst = ins; in_fsqIdx = f; out_ready = rdy; flush = fl; rst = r;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [7:0][31:0] mk(input logic [31:0] base);
    logic [7:0][31:0] v;
    for (int k = 0; k < 8; k++) v[k] = base + 32'(k);
    return v;
  endfunction

  logic [7:0][31:0] zero_ins;

  initial begin
    zero_ins = '0;
    drive(8'h00, zero_ins, 4'h0, 1'b0, 1'b0, 1'b1);
    tick();
    armed = 1'b1;
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_en", 64'(out_en), 64'd0);

`ifndef IBUF_BYPASS_EN
    // Full packet drains in two groups of four
    drive(8'hFF, mk(32'h0), 4'h3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("ff_en0", 64'(out_en), 64'hF);
    for (int i = 0; i < 4; i++) begin
      chk("ff_inst_a", 64'(out_inst[i]), 64'(i));
      chk("ff_off_a", 64'(out_offset[i]), 64'(i));
      chk("ff_fsq_a", 64'(out_fsqIdx[i]), 64'd3);
    end
    tick();
    for (int i = 0; i < 4; i++) chk("ff_inst_b", 64'(out_inst[i]), 64'(i + 4));
    tick();
    chk("ff_empty_en", 64'(out_en), 64'd0);
    chk("ff_empty_cnt", 64'(count), 64'd0);

    // Sparse packet: lanes 0, 2, 5 and 7 are compacted
    drive(8'b1010_0101, mk(32'h100), 4'h5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("sp_en", 64'(out_en), 64'hF);
    chk("sp_i0", {out_inst[0], 29'b0, out_offset[0]}, {32'h100, 32'd0});
    chk("sp_i1", {out_inst[1], 29'b0, out_offset[1]}, {32'h102, 32'd2});
    chk("sp_i2", {out_inst[2], 29'b0, out_offset[2]}, {32'h105, 32'd5});
    chk("sp_i3", {out_inst[3], 29'b0, out_offset[3]}, {32'h107, 32'd7});
    tick();
`endif

    // Fill with decode stalled; a third packet is refused while full
    drive(8'hFF, mk(32'h200), 4'h1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'hFF, mk(32'h300), 4'h2, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fill_cnt8", 64'(count), 64'd8);
    chk("fill_full0", 64'(full), 64'd0);
    tick();
    drive(8'hFF, mk(32'h400), 4'h3, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fill_cnt16", 64'(count), 64'd16);
    chk("fill_full1", 64'(full), 64'd1);
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("fill_hold_cnt", 64'(count), 64'd16);
    chk("fill_hold_i0", 64'(out_inst[0]), 64'h200);
    chk("fill_hold_i3", 64'(out_inst[3]), 64'h203);
    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (4) tick();
    chk("drain_cnt", 64'(count), 64'd0);

    // count=9, then a packet arrives together with flush
    drive(8'hFF, mk(32'h500), 4'h4, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'h01, mk(32'h600), 4'h4, 1'b0, 1'b0, 1'b0);
    tick();
    drive(8'hFF, mk(32'h700), 4'h6, 1'b1, 1'b1, 1'b0);
    #1;
    chk("fl_pre_cnt", 64'(count), 64'd9);
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("fl_cnt", 64'(count), 64'd0);
    chk("fl_en", 64'(out_en), 64'd0);
    chk("fl_full", 64'(full), 64'd0);
    repeat (2) tick();

`ifdef IBUF_BYPASS_EN
    // Empty buffer: three instructions go straight out in the same cycle
    drive(8'h07, mk(32'h800), 4'h7, 1'b1, 1'b0, 1'b0);
    #1;
    chk("byp_en", 64'(out_en), 64'h7);
    chk("byp_i0", 64'(out_inst[0]), 64'h800);
    tick();
    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    #1;
    chk("byp_cnt", 64'(count), 64'd0);
`endif

    // Randomized traffic: wrap-around, sparse packets, stalls, flush, reset
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] en;
      logic [7:0][31:0] ins;
      int sel;
      sel = $urandom_range(0, 9);
      en  = (sel < 2) ? 8'h00 : (sel < 5) ? 8'hFF : 8'($urandom);
      for (int k = 0; k < 8; k++) ins[k] = $urandom;
      drive(en, ins, 4'($urandom), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 49) == 0), ($urandom_range(0, 99) == 0));
      tick();
    end

    drive(8'h00, zero_ins, 4'h0, 1'b1, 1'b0, 1'b0);
    repeat (6) tick();
    chk("final_cnt", 64'(count), 64'd0);
    armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
